frame_bank_ctrl: RTL and testbench

Ping-pong controller for the edge-map frame buffer that sits between the 1-bit pixel packer and the UART transmitter. It routes packer byte writes into one of two DEPTH-byte banks and swaps banks on each completed frame. On host request it streams the most recent complete frame out through the UART TX handshake, one byte at a time, without ever reading a bank that is being written.

---
 rtl/frame_bank_ctrl.sv | 155 +++++++++++++++
 tb/tb_frame_bank_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_ctrl.sv
// Ping-pong frame bank controller: steers packer byte writes into one of two
// banks and streams the most recent complete frame to the UART TX on request.
module frame_bank_ctrl #(
  parameter int DEPTH = 5100,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          frame_tick,
  input  logic          send_req,
  output logic          mem0_we,
  output logic          mem1_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [7:0]    mem0_rdata,
  input  logic [7:0]    mem1_rdata,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic          frame_valid,
  output logic          sending,
  output logic          send_done,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_START,
    S_TX_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic          req_pending_q, req_pending_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic idle;
  logic last_byte;

  assign idle      = (state_q == S_IDLE);
  assign last_byte = (rd_addr_q == AW'(DEPTH - 1));

  assign mem0_we   = wr_we & ~wr_bank_q;
  assign mem1_we   = wr_we &  wr_bank_q;
  assign mem_waddr = wr_addr;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_addr_q;

  // tx_start must fire in the same cycle tx_busy is seen low, so it is decoded
  // straight from the state register rather than delayed a cycle.
  assign tx_start    = (state_q == S_TX_START) & ~tx_busy;
  assign tx_data     = tx_data_q;
  assign frame_valid = frame_valid_q;
  assign sending     = ~idle;
  assign send_done   = (state_q == S_DONE);
  assign drop_cnt    = drop_cnt_q;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rd_addr_d     = rd_addr_q;
    tx_data_d     = tx_data_q;
    frame_valid_d = frame_valid_q;
    req_pending_d = req_pending_q;
    drop_cnt_d    = drop_cnt_q;

    // A finished frame is only handed over while the reader is parked;
    // otherwise the writer keeps its bank and the frame is lost.
    if (frame_tick) begin
      if (idle) begin
        wr_bank_d     = ~wr_bank_q;
        frame_valid_d = 1'b1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    if (send_req && idle) begin
      req_pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_pending_q && frame_valid_q && !frame_tick) begin
          state_d       = S_RD_ADDR;
          rd_bank_d     = ~wr_bank_q;
          rd_addr_d     = '0;
          req_pending_d = 1'b0;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tx_data_d = rd_bank_q ? mem1_rdata : mem0_rdata;
        state_d   = S_TX_START;
      end
      S_TX_START: begin
        if (!tx_busy) begin
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_DONE: begin
        // A frame_tick here is a drop, so nothing can set frame_valid this cycle.
        frame_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_addr_q     <= '0;
      tx_data_q     <= '0;
      frame_valid_q <= 1'b0;
      req_pending_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rd_addr_q     <= rd_addr_d;
      tx_data_q     <= tx_data_d;
      frame_valid_q <= frame_valid_d;
      req_pending_q <= req_pending_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Scoreboard bench for frame_bank_ctrl: a frame-level reference model predicts
// bank routing, frame status and the byte stream; a monitor compares TX output.
module tb_frame_bank_ctrl;

  localparam int DEPTH = 5100;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_tick;
  logic          send_req;
  logic          mem0_we, mem1_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [7:0]    mem_wdata, mem0_rdata, mem1_rdata;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy, tx_done;
  logic          frame_valid, sending, send_done;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  frame_bank_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick), .send_req(send_req),
    .mem0_we(mem0_we), .mem1_we(mem1_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem0_rdata(mem0_rdata), .mem1_rdata(mem1_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .frame_valid(frame_valid), .sending(sending), .send_done(send_done),
    .drop_cnt(drop_cnt)
  );

  // Two banks with one-cycle synchronous read
  logic [7:0] bank0 [0:8191];
  logic [7:0] bank1 [0:8191];
  always @(posedge clk) begin
    if (mem0_we) bank0[mem_waddr] <= mem_wdata;
    if (mem1_we) bank1[mem_waddr] <= mem_wdata;
    mem0_rdata <= bank0[mem_raddr];
    mem1_rdata <= bank1[mem_raddr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout at cycle %0d", nm, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: two frame buffers, a writer index, and a reader that is
  // either parked (0), streaming (1) or finishing (2).
  logic [7:0] buf_m [2][DEPTH];
  logic [7:0] exp_q [$];
  int wr_idx_m = 0, act_m = 0, sent_m = 0, drops_m = 0;
  bit valid_m = 0, pend_m = 0;

  initial begin
    bit idle_m, start_m;
    forever begin
      @(posedge clk);
      if (reset) begin
        wr_idx_m = 0; valid_m = 0; pend_m = 0; act_m = 0; sent_m = 0; drops_m = 0;
        exp_q.delete();
      end else begin
        idle_m  = (act_m == 0);
        start_m = idle_m && pend_m && valid_m && !frame_tick;
        if (wr_we) buf_m[wr_idx_m][wr_addr] = wr_data;
        if (frame_tick) begin
          if (idle_m) begin
            wr_idx_m = 1 - wr_idx_m;
            valid_m  = 1;
          end else if (drops_m < 255) begin
            drops_m++;
          end
        end
        if (act_m == 2) begin
          act_m   = 0;
          valid_m = 0;
        end else if (act_m == 1 && tx_done) begin
          sent_m++;
          if (sent_m == DEPTH) act_m = 2;
        end
        if (start_m) begin
          for (int i = 0; i < DEPTH; i++) exp_q.push_back(buf_m[1 - wr_idx_m][i]);
          act_m  = 1;
          pend_m = 0;
          sent_m = 0;
        end else if (send_req && idle_m) begin
          pend_m = 1;
        end
      end
    end
  end

  // UART TX model: tx_done lat cycles after tx_start, busy may linger stall cycles
  int  stall_mode = 0;
  int  stall_cur  = 0;
  initial begin
    bit s;
    int done_in, hold, lat, stall;
    tx_busy = 0; tx_done = 0; done_in = 0; hold = 0; lat = 1; stall = 0;
    forever begin
      @(negedge clk);
      s = tx_start;
      @(posedge clk);
      #1;
      tx_done = 0;
      if (reset) begin
        done_in = 0; hold = 0; tx_busy = 0;
      end else begin
        if (s) begin
          tx_busy = 1;
          lat     = $urandom_range(1, 2);
          done_in = lat;
          stall   = (stall_mode != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        end
        if (done_in > 0) begin
          done_in--;
          if (done_in == 0) begin
            tx_done   = 1;
            hold      = stall;
            stall_cur = stall;
            tx_busy   = (stall > 0);
          end
        end else if (hold > 0) begin
          hold--;
          tx_busy = (hold > 0);
        end
      end
    end
  end

  // Monitor: per-cycle status against the model, scoreboard pop on tx_start
  int bytes_seen  = 0;
  bit gap_armed   = 0;
  int gap_ref     = 0, gap_exp = 0;
  bit first_armed = 0;
  int first_ref   = 0, first_exp = 0;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      chk("we_route", {mem1_we, mem0_we},
          {wr_we && wr_idx_m == 1, wr_we && wr_idx_m == 0});
      if (wr_we) begin
        chk("waddr", mem_waddr, wr_addr);
        chk("wdata", mem_wdata, wr_data);
      end
      chk("frame_valid", frame_valid, valid_m);
      chk("sending", sending, act_m != 0);
      chk("send_done", send_done, act_m == 2);
      chk("drop_cnt", drop_cnt, drops_m);
      if (tx_start) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          chk("tx_start_unexpected", tx_start, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e);
        end
        if (gap_armed) begin
          chk("tx_gap", cyc - gap_ref, gap_exp);
          gap_armed = 0;
        end
        if (first_armed) begin
          chk("first_latency", cyc - first_ref, first_exp);
          first_armed = 0;
        end
      end
      if (tx_done && exp_q.size() > 0) begin
        gap_armed = 1;
        gap_ref   = cyc;
        gap_exp   = (stall_cur > 3) ? stall_cur : 3;
      end
      if (reset) gap_armed = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_frame(input bit addr_pat);
    for (int a = 0; a < DEPTH; a++) begin
      wr_we   = 1;
      wr_addr = AW'(a);
      wr_data = addr_pat ? a[7:0] : 8'($urandom);
      step(1);
    end
    wr_we = 0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (send_done) break;
    end
    if (k == budget) timeout(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bytes_seen >= n) break;
    end
    if (k == budget) timeout(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; wr_we = 0; wr_addr = '0; wr_data = '0; frame_tick = 0; send_req = 0;
    step(3);
    reset = 0;
    @(negedge clk);
    chk("rst_we", {mem1_we, mem0_we}, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_sending", sending, 0);
    chk("rst_send_done", send_done, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;

    // Frame A = address pattern into bank 0
    write_frame(1);
    frame_tick = 1; step(1); frame_tick = 0;
    @(negedge clk);
    chk("fv_after_tick", frame_valid, 1);
    chk("drop_after_tick", drop_cnt, 0);
    @(posedge clk);
    #1;

    // Stream A while the writer fills frame B and frame_ticks are dropped
    bytes_seen = 0;
    send_req = 1; first_ref = cyc; first_exp = 4; first_armed = 1;
    step(1); send_req = 0;
    fork
      write_frame(0);
      begin
        step(200);
        repeat (3) begin frame_tick = 1; step(1); frame_tick = 0; step(7); end
        @(negedge clk);
        chk("drop_3", drop_cnt, 3);
        @(posedge clk);
        #1;
        repeat (300) begin frame_tick = 1; step(1); frame_tick = 0; step(1); end
        @(negedge clk);
        chk("drop_sat", drop_cnt, 255);
        @(posedge clk);
        #1;
      end
    join
    wait_done(40000, "stream_a");
    chk("fv_cleared_a", frame_valid, 0);
    chk("queue_empty_a", exp_q.size(), 0);
    chk("bytes_a", bytes_seen, DEPTH);

    // Request with no frame, then frame B arrives 20 cycles later
    step(5);
    send_req = 1; step(1); send_req = 0;
    step(20);
    chk("pending_idle", sending, 0);
    bytes_seen = 0;
    frame_tick = 1; first_ref = cyc; first_exp = 4; first_armed = 1;
    step(1); frame_tick = 0;
    wait_bytes(101, 2000, "partial_b");

    // Reset mid-frame abandons the stream
    reset = 1; step(2); reset = 0;
    @(negedge clk);
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_sending", sending, 0);
    chk("rst_mid_fv", frame_valid, 0);
    @(posedge clk);
    #1;
    bytes_seen = 0;
    send_req = 1; step(1); send_req = 0;
    step(50);
    chk("held_no_tx", bytes_seen, 0);
    chk("held_sending", sending, 0);
    reset = 1; step(2); reset = 0;

    // Frame C valid, frame D written, then tick collides with reader start
    stall_mode = 1;
    write_frame(0);
    frame_tick = 1; step(1); frame_tick = 0;
    step(3);
    write_frame(0);
    step(3);
    bytes_seen = 0;
    send_req = 1; first_ref = cyc; first_exp = 5; first_armed = 1;
    step(1); send_req = 0;
    frame_tick = 1; step(1); frame_tick = 0;
    wait_done(60000, "stream_d");
    chk("fv_cleared_d", frame_valid, 0);
    chk("queue_empty_d", exp_q.size(), 0);
    chk("bytes_d", bytes_seen, DEPTH);

    for (int a = 0; a < 4; a++) begin
      wr_we = 1; wr_addr = AW'(a); wr_data = 8'($urandom); step(1);
    end
    wr_we = 0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
